// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS write-back stage and its register file.
package mips_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10,
        LS_RSVD = 2'b11
    } load_size_t;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_to_reg;
        load_size_t           load_size;
        logic                 load_unsigned;
        logic [REG_IDX_W-1:0] write_reg;
        logic [DATA_W-1:0]    read_data;
        logic [DATA_W-1:0]    alu_result;
    } mem_wb_t;

    // Little-endian lane pick plus sign/zero extension; the reserved size acts as a word.
    function automatic logic [DATA_W-1:0] extend_load(
        input load_size_t        size,
        input logic              is_unsigned,
        input logic [DATA_W-1:0] word,
        input logic [1:0]        offset
    );
        logic [7:0]        lane_b;
        logic [15:0]       lane_h;
        logic [DATA_W-1:0] result;
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            LS_BYTE: result = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            LS_HALF: result = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 GPR storage with one write port, two read ports and same-cycle write bypass.
module register_file
    import mips_pkg::*;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int DATA_W   = mips_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata1,
    output logic [DATA_W-1:0]    rdata2
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              write_en;

    // Register 0 is never stored into, so it stays at its reset value of zero.
    assign write_en = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
        end else if (write_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 == '0)                     rdata1 = '0;
        else if (write_en && raddr1 == waddr) rdata1 = wdata;
        else                                  rdata1 = regs_q[raddr1];
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == '0)                     rdata2 = '0;
        else if (write_en && raddr2 == waddr) rdata2 = wdata;
        else                                  rdata2 = regs_q[raddr2];
    end

endmodule

// File: rtl/write_back.sv
// MEM/WB stage: stage register, load lane select/extension, commit into the GPRs, retire count.
module write_back
    import mips_pkg::*;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int DATA_W   = mips_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic                 RegWrite,
    input  logic                 MemtoReg,
    input  logic [1:0]           load_size,
    input  logic                 load_unsigned,
    input  logic [REG_IDX_W-1:0] write_reg,
    input  logic [DATA_W-1:0]    read_data,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [REG_IDX_W-1:0] read_reg1,
    input  logic [REG_IDX_W-1:0] read_reg2,
    output logic [DATA_W-1:0]    read_data1,
    output logic [DATA_W-1:0]    read_data2,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_reg,
    output logic [DATA_W-1:0]    wb_data,
    output logic [31:0]          retired_count
);

    mem_wb_t     stage_q, stage_d;
    logic [31:0] retired_q, retired_d;

    // Any bubble source clears the whole stage so wb_reg/wb_data read as zero afterwards.
    always_comb begin
        stage_d = '0;
        if (!(reset || flush || stall)) begin
            stage_d.valid         = valid_in;
            stage_d.reg_write     = RegWrite;
            stage_d.mem_to_reg    = MemtoReg;
            stage_d.load_size     = load_size_t'(load_size);
            stage_d.load_unsigned = load_unsigned;
            stage_d.write_reg     = write_reg;
            stage_d.read_data     = read_data;
            stage_d.alu_result    = alu_result;
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (reset)              retired_d = '0;
        else if (stage_q.valid) retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        stage_q   <= stage_d;
        retired_q <= retired_d;
    end

    always_comb begin
        wb_data = stage_q.alu_result;
        if (stage_q.mem_to_reg) begin
            wb_data = extend_load(stage_q.load_size, stage_q.load_unsigned,
                                  stage_q.read_data, stage_q.alu_result[1:0]);
        end
    end

    assign wb_we         = stage_q.valid && stage_q.reg_write && (stage_q.write_reg != '0);
    assign wb_reg        = stage_q.write_reg;
    assign retired_count = retired_q;

    // Reset also clears storage, so a commit pending on a reset edge is lost.
    register_file #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_register_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_reg),
        .wdata  (wb_data),
        .raddr1 (read_reg1),
        .raddr2 (read_reg2),
        .rdata1 (read_data1),
        .rdata2 (read_data2)
    );

endmodule
